// File: rtl/led_uart_tx.sv
// LED bus change-capture FIFO feeding a UART transmitter (8N1, LSB first).
// Define LED_UART_PARITY_EN to insert an even-parity bit, giving 8E1 frames.
module led_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [7:0]                    iData,
    output logic                          oTx,
    output logic                          oBusy,
    output logic                          oOverflow,
    output logic [$clog2(FIFO_DEPTH):0]   oFifoCount
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudMax   = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  FullCount = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef LED_UART_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    // Change detect and capture FIFO
    logic [7:0]      prev_q, prev_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_q, wr_d;
    logic [PtrW-1:0] rd_q, rd_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;

    // Transmitter
    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
`ifdef LED_UART_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic       push;
    logic       push_ok;
    logic       pop;
    logic       bit_end;
    logic       tx;
    logic [7:0] head;

    assign head    = mem_q[rd_q];
    assign bit_end = (baud_q == BaudMax);

    always_comb begin
        prev_d  = iData;
        push    = (iData != prev_q);
        // A full FIFO still accepts a push when the same edge pops
        push_ok = push && ((count_q != FullCount) || pop);

        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push_ok) begin
            mem_d[wr_q] = iData;
            wr_d        = wr_q + PtrW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PtrW'(1);
        end

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CntW'(1);
        end

        overflow_d = overflow_q | (push & ~push_ok);
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end ? '0 : baud_q + BaudW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef LED_UART_PARITY_EN
        parity_d = parity_q;
`endif
        pop      = 1'b0;
        tx       = 1'b1;

        unique case (state_q)
            StIdle: begin
                tx     = 1'b1;
                baud_d = '0;
                if (count_q != '0) begin
                    pop      = 1'b1;
                    shift_d  = head;
`ifdef LED_UART_PARITY_EN
                    parity_d = ^head;
`endif
                    bit_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                tx = shift_q[0];
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef LED_UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef LED_UART_PARITY_EN
            StParity: begin
                tx = parity_q;
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                tx = 1'b1;
                if (bit_end) begin
                    // Chain straight into the next start bit when data is waiting
                    if (count_q != '0) begin
                        pop      = 1'b1;
                        shift_d  = head;
`ifdef LED_UART_PARITY_EN
                        parity_d = ^head;
`endif
                        bit_d    = '0;
                        baud_d   = '0;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            prev_q     <= 8'h00;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
`ifdef LED_UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            prev_q     <= prev_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
`ifdef LED_UART_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    assign oTx        = tx;
    assign oBusy      = (state_q != StIdle) || (count_q != '0);
    assign oOverflow  = overflow_q;
    assign oFifoCount = count_q;

endmodule

// File: tb/tb_led_uart_tx.sv
// Directed bench for led_uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
module tb_led_uart_tx;

    logic       Clock;
    logic       Reset;
    logic [7:0] iData;
    logic       oTx;
    logic       oBusy;
    logic       oOverflow;
    logic [2:0] oFifoCount;

    int n_cmp = 0;
    int n_err = 0;

    led_uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iData      (iData),
        .oTx        (oTx),
        .oBusy      (oBusy),
        .oOverflow  (oOverflow),
        .oFifoCount (oFifoCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry: sampled inside the start bit. Exit: sampled in the first stop-bit cycle.
    task automatic frame(input string tag, input logic [7:0] b);
        chk({tag, " start"}, oTx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(4);
            chk($sformatf("%s d%0d", tag, i), oTx, b[i]);
        end
`ifdef LED_UART_PARITY_EN
        tick(4);
        chk({tag, " parity"}, oTx, ^b);
`endif
        tick(4);
        chk({tag, " stop"}, oTx, 1'b1);
    endtask

    int  rises;
    int  prev_busy;
    int  tx_low;

    initial begin
        Reset = 1'b0;
        iData = 8'h3C;

        // Reset held with nonzero data on the bus
        tick(1);
        chk("rst tx", oTx, 1'b1);
        chk("rst busy", oBusy, 1'b0);
        tick(2);
        chk("rst tx3", oTx, 1'b1);
        chk("rst busy3", oBusy, 1'b0);
        chk("rst cnt3", oFifoCount, 3'd0);
        chk("rst ovf3", oOverflow, 1'b0);
        Reset = 1'b1;
        tick(1);
        chk("cap 3c cnt", oFifoCount, 3'd1);
        chk("cap 3c tx", oTx, 1'b1);
        tick(1);
        chk("cap 3c cnt pop", oFifoCount, 3'd0);
        frame("f3c", 8'h3C);
        tick(4);
        chk("f3c done busy", oBusy, 1'b0);

        // Single byte A5 from a clean 00 bus
        Reset = 1'b0;
        iData = 8'h00;
        tick(2);
        Reset = 1'b1;
        tick(5);
        chk("a5 pre busy", oBusy, 1'b0);
        chk("a5 pre cnt", oFifoCount, 3'd0);
        iData = 8'hA5;
        tick(1);
        chk("a5 push cnt", oFifoCount, 3'd1);
        chk("a5 push tx", oTx, 1'b1);
        tick(1);
        chk("a5 pop cnt", oFifoCount, 3'd0);
        chk("a5 busy", oBusy, 1'b1);
        frame("fa5", 8'hA5);
        chk("a5 stop busy", oBusy, 1'b1);
        tick(3);
        chk("a5 last stop busy", oBusy, 1'b1);
        tick(1);
        chk("a5 end busy", oBusy, 1'b0);
        chk("a5 end tx", oTx, 1'b1);

        // Constant bus after capture sends exactly one frame
        iData     = 8'h5A;
        prev_busy = 0;
        rises     = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (oBusy && prev_busy == 0) rises++;
            prev_busy = int'(oBusy);
        end
        chk("5a frame count", rises, 1);
        chk("5a idle busy", oBusy, 1'b0);

        // Six consecutive changes: 1..5 sent back to back, 6 dropped
        iData = 8'h01;
        tick(1);
        chk("burst e1 cnt", oFifoCount, 3'd1);
        iData = 8'h02;
        tick(1);
        chk("burst e2 cnt", oFifoCount, 3'd1);
        chk("burst e2 tx", oTx, 1'b0);
        iData = 8'h03;
        tick(1);
        chk("burst e3 cnt", oFifoCount, 3'd2);
        iData = 8'h04;
        tick(1);
        chk("burst e4 cnt", oFifoCount, 3'd3);
        iData = 8'h05;
        tick(1);
        chk("burst e5 cnt", oFifoCount, 3'd4);
        chk("burst e5 ovf", oOverflow, 1'b0);
        iData = 8'h06;
        frame("b1", 8'h01);
        chk("burst ovf", oOverflow, 1'b1);
        tick(1);
        frame("b2", 8'h02);
        tick(4);
        frame("b3", 8'h03);
        tick(4);
        frame("b4", 8'h04);
        tick(4);
        frame("b5", 8'h05);
        tick(3);
        chk("burst last busy", oBusy, 1'b1);
        tick(1);
        chk("burst end busy", oBusy, 1'b0);
        chk("burst end cnt", oFifoCount, 3'd0);
        tick(20);
        chk("burst ovf sticky", oOverflow, 1'b1);

        // Reset in the middle of an FF frame with another byte queued
        iData = 8'hFF;
        tick(2);
        chk("ff start tx", oTx, 1'b0);
        tick(8);
        iData = 8'h11;
        tick(1);
        chk("ff data tx", oTx, 1'b1);
        chk("ff queued cnt", oFifoCount, 3'd1);
        Reset = 1'b0;
        iData = 8'h00;
        tick(1);
        chk("mid rst tx", oTx, 1'b1);
        chk("mid rst cnt", oFifoCount, 3'd0);
        chk("mid rst ovf", oOverflow, 1'b0);
        chk("mid rst busy", oBusy, 1'b0);
        Reset = 1'b1;
        tx_low = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (oTx !== 1'b1) tx_low++;
        end
        chk("post rst line idle", tx_low, 0);
        chk("post rst busy", oBusy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
